// File: rtl/param_parking_if.sv
// Keypad/sensor/actuator bundle for the parking entry controller.
// The master drives the sensors and keypad; the slave is the controller.
interface param_parking_if #(
  parameter int unsigned PIN_WIDTH    = 16,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned CAPACITY     = 8
);
  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

  logic                 vehicle_arrival;
  logic                 vehicle_left;
  logic                 vehicle_exit;
  logic [PIN_WIDTH-1:0] code;
  logic                 code_ack;
  logic                 open_gate;
  logic                 close_gate;
  logic                 wrong_pin;
  logic                 blocked_gate;
  logic                 lot_full;
  logic [OCC_W-1:0]     occupancy;
  logic [ATT_W-1:0]     attempts;

  modport master (
    output vehicle_arrival, vehicle_left, vehicle_exit, code, code_ack,
    input  open_gate, close_gate, wrong_pin, blocked_gate, lot_full, occupancy, attempts
  );

  modport slave (
    input  vehicle_arrival, vehicle_left, vehicle_exit, code, code_ack,
    output open_gate, close_gate, wrong_pin, blocked_gate, lot_full, occupancy, attempts
  );
endinterface

// File: rtl/param_parking_controller.sv
// Parking-lot entry gate controller: PIN check with lockout, admin recovery,
// gate-open timeout and occupancy tracking with a lot-full entry lockout.
module param_parking_controller #(
  parameter int unsigned          PIN_WIDTH    = 16,
  parameter logic [PIN_WIDTH-1:0] CORRECT_CODE = PIN_WIDTH'(16'h2468),
  parameter logic [PIN_WIDTH-1:0] ADMIN_CODE   = PIN_WIDTH'(16'hBEEF),
  parameter int unsigned          MAX_ATTEMPTS = 3,
  parameter int unsigned          CAPACITY     = 8,
  parameter int unsigned          OPEN_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  param_parking_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TMO_W = $clog2(OPEN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PIN = 3'd1,
    S_WRONG    = 3'd2,
    S_OPEN     = 3'd3,
    S_CLOSING  = 3'd4,
    S_BLOCKED  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               ack_q;
  logic               open_q, close_q, wrong_q, blocked_q, full_q;
  logic               ack_rise;
  logic               occ_inc;
  logic               occ_is_full;

  assign ack_rise    = bus.code_ack & ~ack_q;
  assign occ_is_full = (occ_q == OCC_W'(CAPACITY));

  // Next-state and session counters
  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    tmo_d   = tmo_q;
    occ_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.vehicle_arrival && !occ_is_full) state_d = S_WAIT_PIN;
      end
      S_WAIT_PIN: begin
        if (ack_rise) begin
          if (bus.code == CORRECT_CODE) begin
            state_d = S_OPEN;
            att_d   = '0;
            tmo_d   = '0;
          end else begin
            state_d = S_WRONG;
            att_d   = att_q + ATT_W'(1);
          end
        end
      end
      S_WRONG: begin
        state_d = (att_q == ATT_W'(MAX_ATTEMPTS)) ? S_BLOCKED : S_WAIT_PIN;
      end
      S_OPEN: begin
        if (bus.vehicle_left) begin
          occ_inc = 1'b1;
          state_d = bus.vehicle_arrival ? S_BLOCKED : S_CLOSING;
        end else if (tmo_q == TMO_W'(OPEN_TIMEOUT - 1)) begin
          state_d = S_CLOSING;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CLOSING: state_d = S_IDLE;
      S_BLOCKED: begin
        if (ack_rise && (bus.code == ADMIN_CODE)) begin
          state_d = S_IDLE;
          att_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating occupancy; simultaneous entry and exit cancel out
  always_comb begin
    occ_d = occ_q;
    if (occ_inc && !bus.vehicle_exit) begin
      if (!occ_is_full) occ_d = occ_q + OCC_W'(1);
    end else if (bus.vehicle_exit && !occ_inc) begin
      if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      att_q     <= '0;
      tmo_q     <= '0;
      occ_q     <= '0;
      ack_q     <= 1'b0;
      open_q    <= 1'b0;
      close_q   <= 1'b0;
      wrong_q   <= 1'b0;
      blocked_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      att_q     <= att_d;
      tmo_q     <= tmo_d;
      occ_q     <= occ_d;
      ack_q     <= bus.code_ack;
      open_q    <= (state_d == S_OPEN);
      close_q   <= (state_d == S_CLOSING);
      wrong_q   <= (state_d == S_WRONG);
      blocked_q <= (state_d == S_BLOCKED);
      full_q    <= (occ_d == OCC_W'(CAPACITY));
    end
  end

  assign bus.open_gate    = open_q;
  assign bus.close_gate   = close_q;
  assign bus.wrong_pin    = wrong_q;
  assign bus.blocked_gate = blocked_q;
  assign bus.lot_full     = full_q;
  assign bus.occupancy    = occ_q;
  assign bus.attempts     = att_q;
endmodule

// File: tb/tb_param_parking_controller.sv
// Directed bench for param_parking_controller with hand-computed expectations.
module tb_param_parking_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   exp_occ = 0;

  param_parking_if #(.PIN_WIDTH(16), .MAX_ATTEMPTS(3), .CAPACITY(8)) bus ();

  param_parking_controller #(
    .PIN_WIDTH(16), .CORRECT_CODE(16'h2468), .ADMIN_CODE(16'hBEEF),
    .MAX_ATTEMPTS(3), .CAPACITY(8), .OPEN_TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_pin(input logic [15:0] c);
    bus.code     = c;
    bus.code_ack = 1'b1;
    tick();
    bus.code_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.vehicle_arrival = 1'b0;
    bus.vehicle_left    = 1'b0;
    bus.vehicle_exit    = 1'b0;
    bus.code            = '0;
    bus.code_ack        = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({bus.open_gate, bus.close_gate, bus.wrong_pin, bus.blocked_gate, bus.lot_full} !== 5'b0
        || bus.occupancy !== 4'd0 || bus.attempts !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold: outs=%b occ=%0d att=%0d want all 0",
               {bus.open_gate, bus.close_gate, bus.wrong_pin, bus.blocked_gate, bus.lot_full},
               bus.occupancy, bus.attempts);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({bus.open_gate, bus.close_gate, bus.wrong_pin, bus.blocked_gate, bus.lot_full} !== 5'b0) begin
      bad++;
      $display("FAIL reset_release: outs=%b want 00000",
               {bus.open_gate, bus.close_gate, bus.wrong_pin, bus.blocked_gate, bus.lot_full});
    end
  endtask

  task automatic test_open_pass();
    bus.vehicle_arrival = 1'b1;
    tick();
    enter_pin(16'h2468);
    total++;
    if (bus.open_gate !== 1'b1) begin
      bad++; $display("FAIL pass_open: open_gate=%b want 1", bus.open_gate);
    end
    bus.vehicle_arrival = 1'b0;
    bus.vehicle_left    = 1'b1;
    tick();
    bus.vehicle_left    = 1'b0;
    exp_occ = 1;
    total++;
    if (bus.close_gate !== 1'b1 || bus.open_gate !== 1'b0 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL pass_close: close=%b open=%b occ=%0d want 1 0 %0d",
               bus.close_gate, bus.open_gate, bus.occupancy, exp_occ);
    end
    tick();
    total++;
    if (bus.close_gate !== 1'b0 || bus.attempts !== 2'd0 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL pass_idle: close=%b att=%0d occ=%0d want 0 0 %0d",
               bus.close_gate, bus.attempts, bus.occupancy, exp_occ);
    end
  endtask

  task automatic test_wrong_block();
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      enter_pin(16'h1111);
      total++;
      if (bus.wrong_pin !== 1'b1 || bus.attempts !== 2'(i)) begin
        bad++;
        $display("FAIL wrong_%0d: wrong_pin=%b att=%0d want 1 %0d", i, bus.wrong_pin, bus.attempts, i);
      end
      tick();
      total++;
      if (bus.wrong_pin !== 1'b0 || bus.blocked_gate !== (i == 3)) begin
        bad++;
        $display("FAIL after_wrong_%0d: wrong_pin=%b blocked=%b want 0 %b",
                 i, bus.wrong_pin, bus.blocked_gate, (i == 3));
      end
    end
    enter_pin(16'h2468);
    total++;
    if (bus.blocked_gate !== 1'b1 || bus.open_gate !== 1'b0 || bus.wrong_pin !== 1'b0
        || bus.attempts !== 2'd3) begin
      bad++;
      $display("FAIL blocked_ignore: blocked=%b open=%b wrong=%b att=%0d want 1 0 0 3",
               bus.blocked_gate, bus.open_gate, bus.wrong_pin, bus.attempts);
    end
    tick();
    enter_pin(16'hBEEF);
    total++;
    if (bus.blocked_gate !== 1'b0 || bus.attempts !== 2'd0) begin
      bad++;
      $display("FAIL admin_unlock: blocked=%b att=%0d want 0 0", bus.blocked_gate, bus.attempts);
    end
  endtask

  task automatic test_held_ack();
    int pulses = 0;
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    bus.code     = 16'h1111;
    bus.code_ack = 1'b1;
    repeat (10) begin
      tick();
      if (bus.wrong_pin === 1'b1) pulses++;
    end
    bus.code_ack = 1'b0;
    total++;
    if (pulses != 1 || bus.attempts !== 2'd1) begin
      bad++;
      $display("FAIL held_ack: pulses=%0d att=%0d want 1 1", pulses, bus.attempts);
    end
    tick();
    enter_pin(16'h2468);
    total++;
    if (bus.open_gate !== 1'b1 || bus.attempts !== 2'd0) begin
      bad++;
      $display("FAIL held_recover: open=%b att=%0d want 1 0", bus.open_gate, bus.attempts);
    end
    bus.vehicle_left = 1'b1;
    tick();
    bus.vehicle_left = 1'b0;
    exp_occ++;
    tick();
  endtask

  task automatic test_timeout();
    int  open_cnt = 0;
    logic closed = 1'b0;
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    enter_pin(16'h2468);
    if (bus.open_gate === 1'b1) open_cnt++;
    for (int k = 0; k < 40 && !closed; k++) begin
      tick();
      if (bus.open_gate === 1'b1) open_cnt++;
      if (bus.close_gate === 1'b1) closed = 1'b1;
    end
    total++;
    if (!closed || open_cnt != 16 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL timeout: closed=%b open_cycles=%0d occ=%0d want 1 16 %0d",
               closed, open_cnt, bus.occupancy, exp_occ);
    end
    tick();
  endtask

  task automatic test_lot_full();
    while (exp_occ < 8) begin
      bus.vehicle_arrival = 1'b1;
      tick();
      bus.vehicle_arrival = 1'b0;
      enter_pin(16'h2468);
      bus.vehicle_left = 1'b1;
      tick();
      bus.vehicle_left = 1'b0;
      tick();
      exp_occ++;
    end
    total++;
    if (bus.occupancy !== 4'd8 || bus.lot_full !== 1'b1) begin
      bad++;
      $display("FAIL fill: occ=%0d full=%b want 8 1", bus.occupancy, bus.lot_full);
    end
    bus.vehicle_arrival = 1'b1;
    repeat (3) tick();
    enter_pin(16'h1111);
    total++;
    if (bus.wrong_pin !== 1'b0 || bus.open_gate !== 1'b0 || bus.attempts !== 2'd0) begin
      bad++;
      $display("FAIL full_ignore: wrong=%b open=%b att=%0d want 0 0 0",
               bus.wrong_pin, bus.open_gate, bus.attempts);
    end
    bus.vehicle_arrival = 1'b0;
    bus.vehicle_exit = 1'b1;
    tick();
    bus.vehicle_exit = 1'b0;
    total++;
    if (bus.occupancy !== 4'd7 || bus.lot_full !== 1'b0) begin
      bad++;
      $display("FAIL exit_one: occ=%0d full=%b want 7 0", bus.occupancy, bus.lot_full);
    end
    repeat (8) begin
      bus.vehicle_exit = 1'b1;
      tick();
      bus.vehicle_exit = 1'b0;
      tick();
    end
    exp_occ = 0;
    total++;
    if (bus.occupancy !== 4'd0) begin
      bad++;
      $display("FAIL exit_floor: occ=%0d want 0", bus.occupancy);
    end
  endtask

  task automatic test_tailgate();
    bus.vehicle_arrival = 1'b1;
    tick();
    enter_pin(16'h2468);
    bus.vehicle_left = 1'b1;
    tick();
    bus.vehicle_left    = 1'b0;
    bus.vehicle_arrival = 1'b0;
    exp_occ++;
    total++;
    if (bus.blocked_gate !== 1'b1 || bus.open_gate !== 1'b0 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL tailgate: blocked=%b open=%b occ=%0d want 1 0 %0d",
               bus.blocked_gate, bus.open_gate, bus.occupancy, exp_occ);
    end
    bus.vehicle_exit = 1'b1;
    tick();
    bus.vehicle_exit = 1'b0;
    exp_occ--;
    total++;
    if (bus.occupancy !== 4'(exp_occ) || bus.blocked_gate !== 1'b1) begin
      bad++;
      $display("FAIL blocked_exit: occ=%0d blocked=%b want %0d 1", bus.occupancy, bus.blocked_gate, exp_occ);
    end
    enter_pin(16'hBEEF);
    tick();
  endtask

  task automatic test_back_to_back();
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    enter_pin(16'h2468);
    bus.vehicle_left = 1'b1;
    tick();
    bus.vehicle_left = 1'b0;
    tick();
    exp_occ++;
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    enter_pin(16'h2468);
    bus.vehicle_left = 1'b1;
    bus.vehicle_exit = 1'b1;
    tick();
    bus.vehicle_left = 1'b0;
    bus.vehicle_exit = 1'b0;
    total++;
    if (bus.close_gate !== 1'b1 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL entry_exit_same: close=%b occ=%0d want 1 %0d", bus.close_gate, bus.occupancy, exp_occ);
    end
    tick();
  endtask

  task automatic test_reset_mid_open();
    bus.vehicle_arrival = 1'b1;
    tick();
    bus.vehicle_arrival = 1'b0;
    enter_pin(16'h2468);
    total++;
    if (bus.open_gate !== 1'b1 || bus.occupancy !== 4'(exp_occ)) begin
      bad++;
      $display("FAIL pre_reset_open: open=%b occ=%0d want 1 %0d", bus.open_gate, bus.occupancy, exp_occ);
    end
    #2 rst = 1'b1;
    #1;
    exp_occ = 0;
    total++;
    if (bus.open_gate !== 1'b0 || bus.occupancy !== 4'd0 || bus.attempts !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_open: open=%b occ=%0d att=%0d want 0 0 0",
               bus.open_gate, bus.occupancy, bus.attempts);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_open_pass();
    test_wrong_block();
    test_held_ack();
    test_timeout();
    test_lot_full();
    test_tailgate();
    test_back_to_back();
    test_reset_mid_open();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_parking_controller.md
Name: param_parking_controller

Overview:
Next-generation gate controller for the parking-lot entry.
- Adds parametrised PIN width, attempt limit, lot capacity and gate-open timeout to the single-lane entry controller.
- Adds rising-edge PIN qualification, occupancy tracking with a lot-full lockout, and admin-code recovery from BLOCKED.
- Sits between the keypad/sensor front end and the gate actuator driver.

Parameters:
PIN_WIDTH, 16, width of code bus
CORRECT_CODE, 16'h2468, user PIN (PIN_WIDTH bits)
ADMIN_CODE, 16'hBEEF, unlock PIN that releases BLOCKED (PIN_WIDTH bits; must differ from CORRECT_CODE)
MAX_ATTEMPTS, 3, wrong PINs allowed before BLOCKED (>=1)
CAPACITY, 8, lot spaces (>=1)
OPEN_TIMEOUT, 16, cycles gate may stay open without vehicle passing (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
vehicle_arrival  in  1  vehicle present at entry sensor (level)
vehicle_left  in  1  vehicle passed through gate (level, 1+ cycles)
vehicle_exit  in  1  one-cycle pulse, a vehicle left the lot via exit lane
code  in  PIN_WIDTH  keypad value, valid while code_ack high
code_ack  in  1  keypad strobe; only its rising edge is acted on
open_gate  out  1  gate open command
close_gate  out  1  one-cycle close command
wrong_pin  out  1  one-cycle pulse per rejected PIN
blocked_gate  out  1  lockout indicator
lot_full  out  1  occupancy == CAPACITY
occupancy  out  $clog2(CAPACITY+1)  vehicles inside
attempts  out  $clog2(MAX_ATTEMPTS+1)  wrong PINs in current session

Behaviour:
- Reset (async, rst high): state IDLE; occupancy=0, attempts=0, timeout counter=0, ack_q=0. All outputs 0 while rst high and on the first cycle after release.
- PIN strobe: ack_rise = code_ack & ~ack_q. ack_q is registered every cycle. A held code_ack counts as exactly one entry.
- Outputs are Moore decodes of registered state/counters; no input-to-output combinational path.
- States: IDLE, WAIT_PIN, WRONG, OPEN, CLOSING, BLOCKED.
- IDLE:
  - vehicle_arrival & ~lot_full -> WAIT_PIN.
  - When lot_full, arrival is ignored and the block stays in IDLE.
- WAIT_PIN:
  - ack_rise & code==CORRECT_CODE -> OPEN; attempts cleared; timeout counter cleared.
  - ack_rise & code!=CORRECT_CODE -> WRONG; attempts+1.
  - ADMIN_CODE entered here is treated as a wrong PIN.
- WRONG (1 cycle, wrong_pin=1):
  - If attempts==MAX_ATTEMPTS -> BLOCKED.
  - Otherwise -> WAIT_PIN.
- OPEN (open_gate=1):
  - vehicle_left & vehicle_arrival (tailgate) -> BLOCKED; occupancy+1.
  - vehicle_left alone -> CLOSING; occupancy+1.
  - Timeout counter == OPEN_TIMEOUT-1 with no vehicle_left -> CLOSING; no increment.
  - Otherwise the timeout counter increments.
- CLOSING (1 cycle, close_gate=1) -> IDLE.
- BLOCKED (blocked_gate=1; open_gate=0):
  - Exits only on ack_rise & code==ADMIN_CODE -> IDLE; attempts cleared.
  - Any other code is ignored; no wrong_pin pulse, attempts unchanged.
- Occupancy:
  - Entry increment (OPEN exit via vehicle_left) and vehicle_exit decrement in the same cycle -> net unchanged.
  - Saturating: decrement at 0 is ignored; increment at CAPACITY is ignored.
  - vehicle_exit is honoured in every state, including BLOCKED.
- lot_full:
  - lot_full = (occupancy==CAPACITY).
  - Only gates the IDLE->WAIT_PIN transition; a session already in progress completes normally.
- Session abandon: vehicle_arrival dropping in WAIT_PIN does not abort the session; the FSM waits for a PIN.
- attempts is held from WAIT_PIN through BLOCKED and is visible on the attempts port.
- Illegal state encodings -> IDLE on the next clock with counters unchanged.
- Reset mid-operation (e.g. in OPEN) immediately drops open_gate and clears all counters, including occupancy.

Test Plan:
- Arrival, ack_rise with 16'h2468 -> open_gate high next cycle. vehicle_left -> close_gate pulse 1 cycle, then IDLE; occupancy=1, attempts=0.
- Three wrong codes (16'h1111), each a separate ack rise -> wrong_pin pulses ×3, attempts 1,2,3. After the third, blocked_gate=1. 16'h2468 then ignored; 16'hBEEF -> IDLE, attempts=0.
- code_ack held high for 10 cycles with a wrong code -> exactly one wrong_pin pulse, attempts=1.
- Correct PIN, no vehicle_left for 16 cycles -> close_gate pulse after exactly 16 open cycles; occupancy unchanged.
- Fill the lot to 8 entries -> lot_full=1; further arrival stays IDLE. vehicle_exit pulse -> occupancy=7, lot_full=0. vehicle_exit at occupancy 0 -> stays 0.
- In OPEN, vehicle_left and vehicle_arrival together -> BLOCKED, occupancy+1. Separately, assert rst mid-OPEN -> open_gate=0 in the same cycle, all counters 0.
